fir_ctrl: RTL and testbench
===========================

# fir_ctrl

Control and configuration front end for the FIR engine. It terminates the AXI-Lite slave port and holds the block-level registers: ap_start/ap_done/ap_idle at 0x00 and data_length at 0x10. It maps tap coefficients at 0x20–0x48 onto the single-port tap BRAM. It also arbitrates that BRAM between AXI-Lite and the FIR datapath, and sequences engine start and done.

## Interface
- pADDR_WIDTH, 12, AXI-Lite and BRAM address width
- pDATA_WIDTH, 32, data width
- Tape_Num, 11, number of taps
- axis_clk  in  1  single clock for all logic
- axis_rst  in  1  asynchronous, active-high reset
- awvalid/awready, awaddr  in/out, in  1/1, 12  write-address handshake and address
- wvalid/wready, wdata  in/out, in  1/1, 32  write-data handshake and data
- arvalid/arready, araddr  in/out, in  1/1, 12  read-address handshake and address
- rvalid/rready, rdata  out/in, out  1/1, 32  read-data handshake and data
- tap_WE, tap_EN, tap_Di, tap_A  out  4, 1, 32, 12  tap BRAM port (A is a byte address)
- tap_Do  in  32  tap BRAM read data, 1-cycle synchronous latency
- eng_tap_req  in  1  engine requests the tap port this cycle
- eng_tap_idx  in  4  tap index 0..10
- eng_tap_data  out  32  tap_Do passthrough to the engine
- eng_start  out  1  one-cycle start pulse
- eng_done  in  1  one-cycle pulse when the last output has been accepted
- data_length  out  32  value of register 0x10

## Operation
- Register 0x00:
  - bit0 ap_start: write 1 while idle arms it; self-clears.
  - bit1 ap_done: set by eng_done; cleared by any read of 0x00 when the read completes.
  - bit2 ap_idle: cleared on start, set by eng_done.
  - Other bits read 0.
- Write FSM: states W_ADDR → W_DATA → W_ADDR.
  - W_ADDR: awready=1. awvalid latches awaddr and moves to W_DATA.
  - W_DATA: wready=1, independent of wvalid. On wvalid the write commits in the same cycle and the FSM returns to W_ADDR.
  - There is no B channel.
- Read FSM: states R_ADDR → R_FETCH → R_VALID → R_ADDR.
  - R_ADDR: arready=1. arvalid latches araddr.
  - R_FETCH: issues the BRAM read for tap addresses (one cycle).
  - R_VALID: rvalid=1. rdata is held until rready.
- Tap writes: tap_EN=1, tap_WE=4'hF, tap_A=awaddr-0x20, tap_Di=wdata.
- Tap reads: tap_EN=1, tap_WE=0, tap_A=araddr-0x20.
- Port priority:
  - Busy (ap_idle=0): the engine owns the tap port. tap_A=eng_tap_idx<<2 and tap_EN=eng_tap_req.
  - Idle: AXI-Lite write takes priority over AXI-Lite read. A colliding read stays in R_FETCH one extra cycle.
- Writes while busy:
  - Writes to 0x10 and 0x20–0x48 are dropped (wready still completes).
  - Writing 1 to bit0 while busy is ignored.
- Reads while busy:
  - Tap reads return 0xFFFF_FFFF with no BRAM access.
  - 0x00 and 0x10 always read live values.
- Unmapped addresses (including 0x4C–0xFFF): writes are dropped, reads return 0.

## Timing
- Reset values: awready=1, arready=1, wready=0, rvalid=0, rdata=0, tap_EN=0, tap_WE=0, tap_A=0, tap_Di=0, eng_start=0, data_length=0. Internal: ap_start=0, ap_done=0, ap_idle=1.
- Start sequence, with wvalid high at edge N and wdata[0]=1:
  - eng_start=1 during cycle N+1.
  - ap_start reads 1 only in cycle N+1.
  - ap_idle reads 0 from N+1.
- eng_done at edge M: ap_done=1 and ap_idle=1 from M+1.
- Simultaneous eng_done and completion of a 0x00 read: the read returns the pre-update value, and ap_done ends set.
- Read latency: 2 cycles from the arvalid&arready edge to rvalid, or 3 cycles on a BRAM collision.
- Write to a register: the new value is visible to a read issued on the next cycle.
- Reset asserted mid-transaction: both FSMs return to their address states and partial transactions are discarded.
- Engine tap path: eng_tap_data is valid 1 cycle after eng_tap_req.

## Structure
- fir_ctrl_pkg holds the address constants (ADDR_AP=0x00, ADDR_LEN=0x10, ADDR_TAP_BASE=0x20, ADDR_TAP_LAST=0x48), the ap bit positions and the FSM state enums.
- One natural sub-module, fir_tap_arb, holds the tap-port mux and priority logic. The AXI-Lite FSMs and the registers stay in fir_ctrl.

## Test plan
- Reset → idle values; write 0x10=600, write 0x20+4k=coef[k] (0,-10,-9,23,56,63,56,23,-9,-10,0) → the read-back of each tap matches, and a read of 0x10 returns 600.
- Idle: write 0x00=1 → eng_start one cycle; 0x00 reads with bit2=0 and bit0=0.
- Busy: write 0x24=99, then read 0x24 → 0xFFFF_FFFF; after eng_done a read of 0x24 returns -10.
- Busy: drive eng_tap_req with idx 5 → tap_A=0x14, eng_tap_data=63 one cycle later.
- eng_done → 0x00 reads 0x6; the next read returns 0x4.
- Idle: a write-data commit to a tap in the same cycle as a tap read fetch → the write lands, and rvalid is delayed one cycle with the correct data.

Source files
------------

// File: rtl/fir_ctrl_pkg.sv
// rtl/fir_ctrl_pkg.sv - shared address map, ap bit positions and FSM state types for fir_ctrl
package fir_ctrl_pkg;

  localparam logic [11:0] ADDR_AP       = 12'h000;
  localparam logic [11:0] ADDR_LEN      = 12'h010;
  localparam logic [11:0] ADDR_TAP_BASE = 12'h020;
  localparam logic [11:0] ADDR_TAP_LAST = 12'h048;

  localparam int AP_START_BIT = 0;
  localparam int AP_DONE_BIT  = 1;
  localparam int AP_IDLE_BIT  = 2;

  typedef enum logic {
    W_ADDR,
    W_DATA
  } w_state_t;

  typedef enum logic [1:0] {
    R_ADDR,
    R_FETCH,
    R_VALID
  } r_state_t;

endpackage

// File: rtl/fir_tap_arb.sv
// rtl/fir_tap_arb.sv - tap BRAM port mux: engine while busy, else AXI-Lite write over read
module fir_tap_arb #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   busy,
  input  logic                   wr_req,
  input  logic [pADDR_WIDTH-1:0] wr_addr,
  input  logic [pDATA_WIDTH-1:0] wr_data,
  input  logic                   rd_req,
  input  logic [pADDR_WIDTH-1:0] rd_addr,
  input  logic                   eng_tap_req,
  input  logic [3:0]             eng_tap_idx,
  output logic                   rd_grant,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A
);

  always_comb begin
    rd_grant = 1'b0;
    tap_WE   = 4'h0;
    tap_EN   = 1'b0;
    tap_Di   = '0;
    tap_A    = '0;
    if (busy) begin
      tap_EN = eng_tap_req;
      tap_A  = {{(pADDR_WIDTH-6){1'b0}}, eng_tap_idx, 2'b00};
    end else if (wr_req) begin
      tap_EN = 1'b1;
      tap_WE = 4'hF;
      tap_A  = wr_addr;
      tap_Di = wr_data;
    end else if (rd_req) begin
      tap_EN   = 1'b1;
      tap_A    = rd_addr;
      rd_grant = 1'b1;
    end
  end

endmodule

// File: rtl/fir_ctrl.sv
// rtl/fir_ctrl.sv - AXI-Lite slave, ap/length registers and engine start/done sequencing
module fir_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  output logic                   awready,
  input  logic                   awvalid,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  output logic                   wready,
  input  logic                   wvalid,
  input  logic [pDATA_WIDTH-1:0] wdata,
  output logic                   arready,
  input  logic                   arvalid,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  input  logic                   eng_tap_req,
  input  logic [3:0]             eng_tap_idx,
  output logic [pDATA_WIDTH-1:0] eng_tap_data,
  output logic                   eng_start,
  input  logic                   eng_done,
  output logic [pDATA_WIDTH-1:0] data_length
);

  localparam logic [pADDR_WIDTH-1:0] TAP_LAST =
    ADDR_TAP_BASE + pADDR_WIDTH'(4 * (Tape_Num - 1));

  w_state_t               w_state;
  r_state_t               r_state;
  logic [pADDR_WIDTH-1:0] awaddr_q;
  logic [pADDR_WIDTH-1:0] araddr_q;
  logic                   rd_from_bram;
  logic                   ap_start;
  logic                   ap_done;
  logic                   ap_idle;
  logic                   busy;
  logic                   wr_commit;
  logic                   wr_is_tap;
  logic                   rd_is_tap;
  logic                   rd_grant;
  logic                   rd_done;
  logic [pDATA_WIDTH-1:0] reg_rdata;

  assign busy         = ~ap_idle;
  assign wr_commit    = (w_state == W_DATA) && wvalid;
  assign wr_is_tap    = (awaddr_q >= ADDR_TAP_BASE) && (awaddr_q <= TAP_LAST);
  assign rd_is_tap    = (araddr_q >= ADDR_TAP_BASE) && (araddr_q <= TAP_LAST);
  assign rd_done      = (r_state == R_VALID) && rvalid && rready;
  assign eng_tap_data = tap_Do;

  fir_tap_arb #(
    .pADDR_WIDTH (pADDR_WIDTH),
    .pDATA_WIDTH (pDATA_WIDTH)
  ) u_tap_arb (
    .busy        (busy),
    .wr_req      (wr_commit && wr_is_tap),
    .wr_addr     (awaddr_q - ADDR_TAP_BASE),
    .wr_data     (wdata),
    .rd_req      ((r_state == R_FETCH) && rd_is_tap),
    .rd_addr     (araddr_q - ADDR_TAP_BASE),
    .eng_tap_req (eng_tap_req),
    .eng_tap_idx (eng_tap_idx),
    .rd_grant    (rd_grant),
    .tap_WE      (tap_WE),
    .tap_EN      (tap_EN),
    .tap_Di      (tap_Di),
    .tap_A       (tap_A)
  );

  // A tap address that never reached the BRAM can only mean the engine owned the port.
  always_comb begin
    reg_rdata = '0;
    if (araddr_q == ADDR_AP) begin
      reg_rdata[AP_START_BIT] = ap_start;
      reg_rdata[AP_DONE_BIT]  = ap_done;
      reg_rdata[AP_IDLE_BIT]  = ap_idle;
    end else if (araddr_q == ADDR_LEN) begin
      reg_rdata = data_length;
    end else if (rd_is_tap) begin
      reg_rdata = '1;
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      w_state  <= W_ADDR;
      awready  <= 1'b1;
      wready   <= 1'b0;
      awaddr_q <= '0;
    end else begin
      case (w_state)
        W_ADDR: if (awvalid) begin
          awaddr_q <= awaddr;
          awready  <= 1'b0;
          wready   <= 1'b1;
          w_state  <= W_DATA;
        end
        W_DATA: if (wvalid) begin
          awready <= 1'b1;
          wready  <= 1'b0;
          w_state <= W_ADDR;
        end
        default: w_state <= W_ADDR;
      endcase
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_state      <= R_ADDR;
      arready      <= 1'b1;
      rvalid       <= 1'b0;
      rdata        <= '0;
      araddr_q     <= '0;
      rd_from_bram <= 1'b0;
    end else begin
      case (r_state)
        R_ADDR: if (arvalid) begin
          araddr_q <= araddr;
          arready  <= 1'b0;
          r_state  <= R_FETCH;
        end
        R_FETCH: begin
          if (busy || !rd_is_tap) begin
            rd_from_bram <= 1'b0;
            r_state      <= R_VALID;
          end else if (rd_grant) begin
            rd_from_bram <= 1'b1;
            r_state      <= R_VALID;
          end
        end
        // First R_VALID cycle captures data once tap_Do has settled; rvalid follows.
        R_VALID: begin
          if (!rvalid) begin
            rvalid <= 1'b1;
            rdata  <= rd_from_bram ? tap_Do : reg_rdata;
          end else if (rready) begin
            rvalid  <= 1'b0;
            arready <= 1'b1;
            r_state <= R_ADDR;
          end
        end
        default: r_state <= R_ADDR;
      endcase
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      ap_start    <= 1'b0;
      ap_done     <= 1'b0;
      ap_idle     <= 1'b1;
      eng_start   <= 1'b0;
      data_length <= '0;
    end else begin
      ap_start  <= 1'b0;
      eng_start <= 1'b0;
      if (wr_commit && ap_idle) begin
        if ((awaddr_q == ADDR_AP) && wdata[AP_START_BIT]) begin
          ap_start  <= 1'b1;
          eng_start <= 1'b1;
          ap_idle   <= 1'b0;
        end
        if (awaddr_q == ADDR_LEN) data_length <= wdata;
      end
      if (rd_done && (araddr_q == ADDR_AP)) ap_done <= 1'b0;
      // eng_done wins over a coinciding read-clear so the completion is not lost.
      if (eng_done) begin
        ap_done <= 1'b1;
        ap_idle <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_ctrl.sv
// tb/tb_fir_ctrl.sv - self-checking bench for fir_ctrl with a tap BRAM and engine stub
module tb_fir_ctrl;

  logic        axis_clk = 1'b0;
  logic        axis_rst = 1'b1;
  logic        awready, awvalid = 1'b0;
  logic [11:0] awaddr = '0;
  logic        wready, wvalid = 1'b0;
  logic [31:0] wdata = '0;
  logic        arready, arvalid = 1'b0;
  logic [11:0] araddr = '0;
  logic        rvalid, rready = 1'b0;
  logic [31:0] rdata;
  logic [3:0]  tap_WE;
  logic        tap_EN;
  logic [31:0] tap_Di;
  logic [11:0] tap_A;
  logic [31:0] tap_Do = '0;
  logic        eng_tap_req = 1'b0;
  logic [3:0]  eng_tap_idx = '0;
  logic [31:0] eng_tap_data;
  logic        eng_start;
  logic        eng_done = 1'b0;
  logic [31:0] data_length;

  int checks = 0;
  int errors = 0;

  logic [31:0] bram [0:15];
  logic [31:0] ref_tap [0:10];
  logic [31:0] ref_len;
  bit          ref_busy;
  bit          ref_done;

  always #5 axis_clk = ~axis_clk;

  fir_ctrl dut (
    .axis_clk     (axis_clk),
    .axis_rst     (axis_rst),
    .awready      (awready),
    .awvalid      (awvalid),
    .awaddr       (awaddr),
    .wready       (wready),
    .wvalid       (wvalid),
    .wdata        (wdata),
    .arready      (arready),
    .arvalid      (arvalid),
    .araddr       (araddr),
    .rvalid       (rvalid),
    .rready       (rready),
    .rdata        (rdata),
    .tap_WE       (tap_WE),
    .tap_EN       (tap_EN),
    .tap_Di       (tap_Di),
    .tap_A        (tap_A),
    .tap_Do       (tap_Do),
    .eng_tap_req  (eng_tap_req),
    .eng_tap_idx  (eng_tap_idx),
    .eng_tap_data (eng_tap_data),
    .eng_start    (eng_start),
    .eng_done     (eng_done),
    .data_length  (data_length)
  );

  always @(posedge axis_clk) begin
    if (tap_EN) begin
      if (tap_WE == 4'hF) bram[tap_A[5:2]] <= tap_Di;
      tap_Do <= bram[tap_A[5:2]];
    end
  end

  function automatic logic [31:0] model_read(input logic [11:0] a);
    if (a == 12'h000) return {29'b0, !ref_busy, ref_done, 1'b0};
    if (a == 12'h010) return ref_len;
    if (a >= 12'h020 && a <= 12'h048)
      return ref_busy ? 32'hFFFF_FFFF : ref_tap[(a - 12'h020) >> 2];
    return 32'h0;
  endfunction

  function automatic void model_write(input logic [11:0] a, input logic [31:0] d);
    if (ref_busy) return;
    if (a == 12'h000) begin
      if (d[0]) ref_busy = 1'b1;
    end else if (a == 12'h010) begin
      ref_len = d;
    end else if (a >= 12'h020 && a <= 12'h048) begin
      ref_tap[(a - 12'h020) >> 2] = d;
    end
  endfunction

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
    int n;
    awaddr = a; awvalid = 1'b1; n = 0;
    while (!awready && n < 20) begin @(posedge axis_clk); #1; n++; end
    @(posedge axis_clk); #1;
    awvalid = 1'b0;
    wdata = d; wvalid = 1'b1;
    while (!wready && n < 20) begin @(posedge axis_clk); #1; n++; end
    @(posedge axis_clk); #1;
    wvalid = 1'b0;
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL write_handshake addr=%h got timeout required ready", a);
    end
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output int lat);
    int n;
    araddr = a; arvalid = 1'b1; n = 0;
    while (!arready && n < 20) begin @(posedge axis_clk); #1; n++; end
    @(posedge axis_clk); #1;
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 20) begin @(posedge axis_clk); #1; lat++; end
    d = rdata;
    rready = 1'b1;
    @(posedge axis_clk); #1;
    rready = 1'b0;
  endtask

  task automatic pulse_done();
    eng_done = 1'b1;
    @(posedge axis_clk); #1;
    eng_done = 1'b0;
    ref_busy = 1'b0;
    ref_done = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int lat;
    repeat (3) @(posedge axis_clk);
    #1;
    checks++;
    if ({awready, arready, wready, rvalid, eng_start} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_handshake got %b required 11000", {awready, arready, wready, rvalid, eng_start});
    end
    checks++;
    if ({tap_EN, tap_WE, tap_A, tap_Di, rdata, data_length} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got en=%b we=%h a=%h di=%h rdata=%h len=%h required all 0",
               tap_EN, tap_WE, tap_A, tap_Di, rdata, data_length);
    end
    axis_rst = 1'b0;
    @(posedge axis_clk); #1;
    axi_read(12'h000, d, lat);
    checks++;
    if (d !== 32'h4) begin
      errors++;
      $display("FAIL reset_ap got %h required 00000004", d);
    end
  endtask

  task automatic test_coef();
    int coef [0:10] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    logic [31:0] d;
    int lat;
    axi_write(12'h010, 32'd600);
    model_write(12'h010, 32'd600);
    for (int k = 0; k < 11; k++) begin
      axi_write(12'(12'h020 + 4 * k), 32'(coef[k]));
      model_write(12'(12'h020 + 4 * k), 32'(coef[k]));
    end
    for (int k = 0; k < 11; k++) begin
      axi_read(12'(12'h020 + 4 * k), d, lat);
      checks++;
      if (d !== 32'(coef[k]) || lat != 2) begin
        errors++;
        $display("FAIL coef_readback k=%0d got %h lat %0d required %h lat 2", k, d, lat, 32'(coef[k]));
      end
    end
    axi_read(12'h010, d, lat);
    checks++;
    if (d !== 32'd600 || data_length !== 32'd600) begin
      errors++;
      $display("FAIL len_readback got %0d port %0d required 600", d, data_length);
    end
  endtask

  task automatic test_start();
    logic [31:0] d;
    int lat;
    axi_write(12'h000, 32'h1);
    model_write(12'h000, 32'h1);
    checks++;
    if (eng_start !== 1'b1) begin
      errors++;
      $display("FAIL start_pulse got %b required 1", eng_start);
    end
    @(posedge axis_clk); #1;
    checks++;
    if (eng_start !== 1'b0) begin
      errors++;
      $display("FAIL start_pulse_end got %b required 0", eng_start);
    end
    axi_read(12'h000, d, lat);
    checks++;
    if (d[2] !== 1'b0 || d[0] !== 1'b0 || d !== model_read(12'h000)) begin
      errors++;
      $display("FAIL ap_busy got %h required %h", d, model_read(12'h000));
    end
  endtask

  task automatic test_busy();
    logic [31:0] d;
    int lat;
    axi_write(12'h024, 32'd99);
    model_write(12'h024, 32'd99);
    axi_write(12'h010, 32'd5);
    model_write(12'h010, 32'd5);
    axi_write(12'h000, 32'h1);
    checks++;
    if (eng_start !== 1'b0) begin
      errors++;
      $display("FAIL busy_restart got %b required 0", eng_start);
    end
    axi_read(12'h024, d, lat);
    checks++;
    if (d !== 32'hFFFF_FFFF || lat != 2) begin
      errors++;
      $display("FAIL busy_tap_read got %h lat %0d required ffffffff lat 2", d, lat);
    end
    axi_read(12'h010, d, lat);
    checks++;
    if (d !== model_read(12'h010)) begin
      errors++;
      $display("FAIL busy_len_read got %0d required %0d", d, model_read(12'h010));
    end
  endtask

  task automatic test_eng_tap();
    int idx;
    for (int i = 0; i < 6; i++) begin
      idx = (i == 0) ? 5 : $urandom_range(0, 10);
      eng_tap_req = 1'b1;
      eng_tap_idx = 4'(idx);
      #1;
      checks++;
      if (tap_A !== 12'(idx * 4) || tap_EN !== 1'b1 || tap_WE !== 4'h0) begin
        errors++;
        $display("FAIL eng_tap_addr idx=%0d got a=%h en=%b we=%h required a=%h en=1 we=0",
                 idx, tap_A, tap_EN, tap_WE, 12'(idx * 4));
      end
      @(posedge axis_clk); #1;
      eng_tap_req = 1'b0;
      checks++;
      if (eng_tap_data !== ref_tap[idx]) begin
        errors++;
        $display("FAIL eng_tap_data idx=%0d got %h required %h", idx, eng_tap_data, ref_tap[idx]);
      end
    end
  endtask

  task automatic test_done();
    logic [31:0] d;
    int lat;
    pulse_done();
    axi_read(12'h000, d, lat);
    checks++;
    if (d !== 32'h6) begin
      errors++;
      $display("FAIL done_ap_first got %h required 00000006", d);
    end
    ref_done = 1'b0;
    axi_read(12'h000, d, lat);
    checks++;
    if (d !== 32'h4) begin
      errors++;
      $display("FAIL done_ap_second got %h required 00000004", d);
    end
    axi_read(12'h024, d, lat);
    checks++;
    if (d !== 32'hFFFF_FFF6) begin
      errors++;
      $display("FAIL done_tap_read got %h required fffffff6", d);
    end
  endtask

  task automatic test_done_collide();
    logic [31:0] d;
    logic [31:0] exp;
    int lat;
    axi_write(12'h000, 32'h1);
    model_write(12'h000, 32'h1);
    araddr = 12'h000; arvalid = 1'b1;
    @(posedge axis_clk); #1;
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 20) begin @(posedge axis_clk); #1; lat++; end
    exp = model_read(12'h000);
    d = rdata;
    rready = 1'b1;
    eng_done = 1'b1;
    @(posedge axis_clk); #1;
    rready = 1'b0;
    eng_done = 1'b0;
    ref_busy = 1'b0;
    ref_done = 1'b1;
    checks++;
    if (d !== exp) begin
      errors++;
      $display("FAIL collide_read_value got %h required %h", d, exp);
    end
    axi_read(12'h000, d, lat);
    ref_done = 1'b0;
    checks++;
    if (d !== 32'h6) begin
      errors++;
      $display("FAIL collide_done_kept got %h required 00000006", d);
    end
  endtask

  task automatic test_collision();
    logic [31:0] v;
    logic [31:0] d;
    int lat;
    v = $urandom;
    awaddr = 12'h030; awvalid = 1'b1;
    araddr = 12'h030; arvalid = 1'b1;
    @(posedge axis_clk); #1;
    awvalid = 1'b0; arvalid = 1'b0;
    wdata = v; wvalid = 1'b1;
    @(posedge axis_clk); #1;
    wvalid = 1'b0;
    model_write(12'h030, v);
    lat = 1;
    while (!rvalid && lat < 20) begin @(posedge axis_clk); #1; lat++; end
    d = rdata;
    rready = 1'b1;
    @(posedge axis_clk); #1;
    rready = 1'b0;
    checks++;
    if (d !== v || lat != 3) begin
      errors++;
      $display("FAIL collision_read got %h lat %0d required %h lat 3", d, lat, v);
    end
    axi_read(12'h030, d, lat);
    checks++;
    if (d !== v || lat != 2) begin
      errors++;
      $display("FAIL collision_write_landed got %h lat %0d required %h lat 2", d, lat, v);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [31:0] v;
    logic [31:0] exp;
    logic [11:0] a;
    bit          was_idle;
    int lat;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 6))
        0: begin
          a = 12'(12'h020 + 4 * $urandom_range(0, 10));
          v = $urandom;
          axi_write(a, v);
          model_write(a, v);
        end
        1, 3: begin
          case ($urandom_range(0, 2))
            0: a = 12'(12'h020 + 4 * $urandom_range(0, 10));
            1: a = 12'h010;
            default: a = 12'h000;
          endcase
          exp = model_read(a);
          axi_read(a, d, lat);
          if (a == 12'h000) ref_done = 1'b0;
          checks++;
          if (d !== exp || lat != 2) begin
            errors++;
            $display("FAIL random_read addr=%h got %h lat %0d required %h lat 2", a, d, lat, exp);
          end
        end
        2: begin
          v = $urandom;
          axi_write(12'h010, v);
          model_write(12'h010, v);
        end
        4: begin
          a = ($urandom_range(0, 1) == 0) ? 12'(4 * $urandom_range(19, 1023))
                                          : 12'(4 * $urandom_range(1, 3));
          axi_write(a, $urandom);
          axi_read(a, d, lat);
          checks++;
          if (d !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_read addr=%h got %h required 0", a, d);
          end
        end
        5: begin
          was_idle = !ref_busy;
          axi_write(12'h000, 32'h1);
          model_write(12'h000, 32'h1);
          checks++;
          if (eng_start !== was_idle) begin
            errors++;
            $display("FAIL random_start got %b required %b", eng_start, was_idle);
          end
        end
        default: if (ref_busy) pulse_done();
      endcase
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int lat;
    awaddr = 12'h010; awvalid = 1'b1;
    araddr = 12'h020; arvalid = 1'b1;
    @(posedge axis_clk); #1;
    awvalid = 1'b0; arvalid = 1'b0;
    axis_rst = 1'b1;
    #1;
    checks++;
    if ({awready, wready, arready, rvalid, data_length} !== {4'b1010, 32'h0}) begin
      errors++;
      $display("FAIL reset_mid got aw=%b w=%b ar=%b r=%b len=%h required 1 0 1 0 0",
               awready, wready, arready, rvalid, data_length);
    end
    @(posedge axis_clk); #1;
    axis_rst = 1'b0;
    ref_len = '0; ref_busy = 1'b0; ref_done = 1'b0;
    @(posedge axis_clk); #1;
    axi_write(12'h010, 32'd77);
    model_write(12'h010, 32'd77);
    axi_read(12'h010, d, lat);
    checks++;
    if (d !== 32'd77 || lat != 2) begin
      errors++;
      $display("FAIL reset_mid_recover got %0d lat %0d required 77 lat 2", d, lat);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) bram[i] = '0;
    for (int i = 0; i < 11; i++) ref_tap[i] = '0;
    ref_len = '0;
    ref_busy = 1'b0;
    ref_done = 1'b0;
    test_reset();
    test_coef();
    test_start();
    test_busy();
    test_eng_tap();
    test_done();
    test_done_collide();
    test_collision();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got no completion required finish");
    $fatal(1);
  end

endmodule
